// File: rtl/pq_stream_driver_if.sv
// Bundle of the stream and priority-queue command signals used by
// pq_stream_driver. The master modport is the driver itself; the slave
// modport is its environment (upstream, downstream and the attached PQ).
interface pq_stream_driver_if #(
    parameter int DATA_WIDTH = 16,
    parameter int QUEUE_SIZE = 8
);
    localparam int COUNT_WIDTH = $clog2(QUEUE_SIZE + 1);

    logic                   i_in_valid;
    logic                   o_in_ready;
    logic [DATA_WIDTH-1:0]  i_in_data;
    logic                   o_out_valid;
    logic                   i_out_ready;
    logic [DATA_WIDTH-1:0]  o_out_data;
    logic                   i_drain;
    logic                   o_pq_wrt;
    logic                   o_pq_read;
    logic [DATA_WIDTH-1:0]  o_pq_data;
    logic [DATA_WIDTH-1:0]  i_pq_data;
    logic [COUNT_WIDTH-1:0] o_count;
    logic                   o_zero_drop;

    modport master (
        input  i_in_valid, i_in_data, i_out_ready, i_drain, i_pq_data,
        output o_in_ready, o_out_valid, o_out_data, o_pq_wrt, o_pq_read,
               o_pq_data, o_count, o_zero_drop
    );

    modport slave (
        output i_in_valid, i_in_data, i_out_ready, i_drain, i_pq_data,
        input  o_in_ready, o_out_valid, o_out_data, o_pq_wrt, o_pq_read,
               o_pq_data, o_count, o_zero_drop
    );
endinterface

// File: rtl/pq_stream_driver.sv
// Initiator-side driver for the register-tree priority queue. Turns an
// input valid/ready stream into single-cycle PQ write/read commands, waits
// out the PQ settle time after every command, tracks occupancy locally and
// returns popped (largest-first) items on an output valid/ready stream.
// Optional feature macro: PQ_REPLACE_EN (write+read in one command when the
// PQ is full, keeping occupancy constant).
module pq_stream_driver #(
    parameter int DATA_WIDTH    = 16,
    parameter int QUEUE_SIZE    = 8,
    parameter int SETTLE_CYCLES = 6
) (
    input  logic                CLK,
    input  logic                RST,
    pq_stream_driver_if.master  bus
);
    localparam int COUNT_WIDTH = $clog2(QUEUE_SIZE + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_FULL  = COUNT_WIDTH'(QUEUE_SIZE);
    localparam logic [7:0]             SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        SETTLE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   pq_wrt_q, pq_wrt_d;
    logic                   pq_read_q, pq_read_d;
    logic [DATA_WIDTH-1:0]  pq_data_q, pq_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   zero_drop_q, zero_drop_d;
    logic [7:0]             settle_q, settle_d;
    logic                   in_ready;

    logic buf_empty, pq_full, pq_nonempty, item_zero, read_urgent, do_replace;

    assign buf_empty   = !out_valid_q;
    assign pq_full     = (count_q == COUNT_FULL);
    assign pq_nonempty = (count_q != '0);
    assign item_zero   = (bus.i_in_data == '0);
    assign read_urgent = pq_nonempty && buf_empty && (bus.i_drain || pq_full);

`ifdef PQ_REPLACE_EN
    assign do_replace = pq_full && bus.i_in_valid && !item_zero && buf_empty && !bus.i_drain;
`else
    assign do_replace = 1'b0;
`endif

    // Next-state, command decision, occupancy and output-buffer update.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        pq_wrt_d    = 1'b0;
        pq_read_d   = 1'b0;
        pq_data_d   = pq_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        count_d     = count_q;
        zero_drop_d = 1'b0;
        settle_d    = settle_q;
        in_ready    = 1'b0;

        if (out_valid_q && bus.i_out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (do_replace) begin
                    in_ready  = 1'b1;
                    pq_data_d = bus.i_in_data;
                    pq_wrt_d  = 1'b1;
                    pq_read_d = 1'b1;
                    state_d   = CMD;
                end else if (read_urgent) begin
                    pq_read_d = 1'b1;
                    state_d   = CMD;
                end else if (bus.i_in_valid && !bus.i_drain && item_zero) begin
                    // The PQ treats 0 as its empty marker: swallow the item.
                    in_ready    = 1'b1;
                    zero_drop_d = 1'b1;
                end else if (bus.i_in_valid && !pq_full && !bus.i_drain) begin
                    in_ready  = 1'b1;
                    pq_data_d = bus.i_in_data;
                    pq_wrt_d  = 1'b1;
                    state_d   = CMD;
                end else if (pq_nonempty && buf_empty) begin
                    pq_read_d = 1'b1;
                    state_d   = CMD;
                end
            end

            CMD: begin
                if (pq_read_q) begin
                    out_data_d  = bus.i_pq_data;
                    out_valid_d = 1'b1;
                end
                if (pq_wrt_q && !pq_read_q && !pq_full) begin
                    count_d = count_q + 1'b1;
                end else if (pq_read_q && !pq_wrt_q && pq_nonempty) begin
                    count_d = count_q - 1'b1;
                end
                settle_d = SETTLE_LAST;
                state_d  = SETTLE;
            end

            SETTLE: begin
                if (settle_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge value of its neighbours.
        if (RST) begin
            state_q     <= IDLE;
            pq_wrt_q    <= 1'b0;
            pq_read_q   <= 1'b0;
            pq_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            count_q     <= '0;
            zero_drop_q <= 1'b0;
            settle_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            pq_wrt_q    <= pq_wrt_d;
            pq_read_q   <= pq_read_d;
            pq_data_q   <= pq_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
            zero_drop_q <= zero_drop_d;
            settle_q    <= settle_d;
        end
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_out_data  = out_data_q;
    assign bus.o_pq_wrt    = pq_wrt_q;
    assign bus.o_pq_read   = pq_read_q;
    assign bus.o_pq_data   = pq_data_q;
    assign bus.o_count     = count_q;
    assign bus.o_zero_drop = zero_drop_q;
endmodule

// File: tb/tb_pq_stream_driver.sv
// Self-checking bench for pq_stream_driver. A behavioural priority queue
// answers the driver's commands; a per-cycle monitor checks the driver
// against a transaction-level model (accepted items, occupancy, popped
// maxima, command spacing); directed sequences pin literal expectations.
module tb_pq_stream_driver;
    localparam int DW = 16;
    localparam int QS = 8;
    localparam int SC = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pq_stream_driver_if #(.DATA_WIDTH(DW), .QUEUE_SIZE(QS)) bus ();

    pq_stream_driver #(.DATA_WIDTH(DW), .QUEUE_SIZE(QS), .SETTLE_CYCLES(SC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural priority queue ----------------
    int pq_q[$];
    logic [DW-1:0] pq_root = '0;
    assign bus.i_pq_data = pq_root;

    function automatic int max_of();
        int m = 0;
        foreach (pq_q[i]) if (pq_q[i] > m) m = pq_q[i];
        return m;
    endfunction

    function automatic void pop_max();
        int idx = 0;
        foreach (pq_q[i]) if (pq_q[i] > pq_q[idx]) idx = i;
        if (pq_q.size() > 0) pq_q.delete(idx);
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            pq_q.delete();
        end else begin
            if (bus.o_pq_read) pop_max();
            if (bus.o_pq_wrt) pq_q.push_back(int'(bus.o_pq_data));
        end
        pq_root <= DW'(max_of());
    end

    // ---------------- per-cycle monitor ----------------
    int cyc = 0;
    int last_cmd = -1000;
    int acc_q[$];
    int exp_out[$];
    int out_log[$];
    int wrt_times[$];
    int read_cnt = 0;
    int rep_cnt = 0;
    bit zd_exp = 1'b0;
    bit rd_prev = 1'b0;

    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            acc_q.delete();
            exp_out.delete();
            zd_exp   = 1'b0;
            rd_prev  = 1'b0;
            last_cmd = -1000;
        end else begin
            check("count_vs_pq", bus.o_count, pq_q.size());
            check("zero_drop", bus.o_zero_drop, zd_exp);
            if (rd_prev) check("valid_after_read", bus.o_out_valid, 1);
`ifdef PQ_REPLACE_EN
            if (bus.o_pq_wrt && bus.o_pq_read) begin
                rep_cnt++;
                check("replace_only_full", bus.o_count, QS);
            end
`else
            check("cmd_exclusive", bus.o_pq_wrt && bus.o_pq_read, 0);
`endif
            if (bus.o_pq_wrt || bus.o_pq_read) begin
                check("cmd_spacing", (cyc - last_cmd) >= SC + 2, 1);
                last_cmd = cyc;
            end
            if (bus.o_pq_wrt) begin
                wrt_times.push_back(cyc);
                if (acc_q.size() == 0) check("wrt_without_item", 1, 0);
                else check("wrt_data", bus.o_pq_data, acc_q.pop_front());
            end
            if (bus.o_pq_read) begin
                read_cnt++;
                check("read_nonempty", pq_q.size() > 0, 1);
                exp_out.push_back(max_of());
            end
            if (bus.o_out_valid) begin
                if (exp_out.size() == 0) begin
                    check("out_without_read", 1, 0);
                end else begin
                    check("out_data", bus.o_out_data, exp_out[0]);
                    if (bus.i_out_ready) begin
                        out_log.push_back(int'(bus.o_out_data));
                        void'(exp_out.pop_front());
                    end
                end
            end
            if (bus.i_in_valid && bus.o_in_ready) begin
                check("ready_no_drain", bus.i_drain, 0);
                if (bus.i_in_data != '0) begin
                    acc_q.push_back(int'(bus.i_in_data));
`ifndef PQ_REPLACE_EN
                    check("ready_not_full", bus.o_count < QS, 1);
`endif
                end
            end
            zd_exp  = bus.i_in_valid && bus.o_in_ready && (bus.i_in_data == '0);
            rd_prev = bus.o_pq_read;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int v);
        bit done = 1'b0;
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = DW'(v);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            if (bus.o_in_ready) begin
                @(posedge CLK);
                #1;
                done = 1'b1;
            end
        end
        check("send_handshake", done, 1);
    endtask

    task automatic wait_out(output int v);
        bit done = 1'b0;
        v = -1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            if (bus.o_out_valid) begin
                v = int'(bus.o_out_data);
                done = 1'b1;
            end
        end
        check("out_valid_seen", done, 1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequences ----------------
    initial begin
        int v, rc, hits, nw, c0;

        bus.i_in_valid  = 1'b0;
        bus.i_in_data   = '0;
        bus.i_out_ready = 1'b0;
        bus.i_drain     = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_pq_wrt", bus.o_pq_wrt, 0);
        check("rst_pq_read", bus.o_pq_read, 0);
        check("rst_pq_data", bus.o_pq_data, 0);
        check("rst_out_valid", bus.o_out_valid, 0);
        check("rst_out_data", bus.o_out_data, 0);
        check("rst_count", bus.o_count, 0);
        check("rst_zero_drop", bus.o_zero_drop, 0);
        RST = 1'b0;

        // Write 5, 9, 3 back to back with the output stalled
        wrt_times.delete();
        send(5);
        send(9);
        send(3);
        bus.i_in_valid = 1'b0;
        tick();
        check("t1_count3", bus.o_count, 3);
        check("t1_no_read_yet", read_cnt, 0);
        check("t1_three_writes", wrt_times.size(), 3);
        if (wrt_times.size() == 3) begin
            check("t1_spacing_a", wrt_times[1] - wrt_times[0], 8);
            check("t1_spacing_b", wrt_times[2] - wrt_times[1], 8);
        end
        wait_out(v);
        check("t1_first_out", v, 9);
        check("t1_count2", bus.o_count, 2);

        // Fill to capacity with 1..8
        do_reset();
        for (int i = 1; i <= 8; i++) send(i);
`ifdef PQ_REPLACE_EN
        send(20);
        bus.i_in_valid = 1'b0;
        wait_out(v);
        check("t2_replace_out", v, 8);
        tick();
        check("t2_replace_count", bus.o_count, 8);
        check("t2_replace_pulses", rep_cnt, 1);
`else
        bus.i_in_data = DW'(20);
        wait_out(v);
        check("t2_full_read_out", v, 8);
        check("t2_count7", bus.o_count, 7);
        send(20);
        repeat (2) tick();
        check("t2_count8", bus.o_count, 8);
`endif
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = DW'(30);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (bus.o_in_ready) hits++;
        end
        check("t2_full_not_ready", hits, 0);
        check("t2_buffer_held", bus.o_out_data, 8);
        check("t2_count_full", bus.o_count, 8);
        @(posedge CLK);
        #1;
        bus.i_in_valid = 1'b0;

        // Drain 2, 7, 4, 6 with the output flowing
        do_reset();
        bus.i_out_ready = 1'b1;
        out_log.delete();
        send(2);
        send(7);
        send(4);
        send(6);
        bus.i_drain   = 1'b1;
        bus.i_in_data = DW'(11);
        hits = 0;
        begin
            bit done = 1'b0;
            for (int i = 0; i < 400 && !done; i++) begin
                @(negedge CLK);
                if (bus.o_in_ready) hits++;
                if (bus.o_count == 0 && !bus.o_out_valid) done = 1'b1;
            end
            check("t3_drain_done", done, 1);
        end
        check("t3_ready_low", hits, 0);
        check("t3_out_count", out_log.size(), 4);
        if (out_log.size() == 4) begin
            check("t3_out0", out_log[0], 7);
            check("t3_out1", out_log[1], 6);
            check("t3_out2", out_log[2], 4);
            check("t3_out3", out_log[3], 2);
        end
        @(posedge CLK);
        #1;
        bus.i_drain = 1'b0;
        send(11);
        bus.i_in_valid = 1'b0;
        wait_out(v);
        check("t3_after_drain", v, 11);

        // Zero item is swallowed
        repeat (10) tick();
        c0 = bus.o_count;
        nw = wrt_times.size();
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = '0;
        @(negedge CLK);
        check("t4_zero_ready", bus.o_in_ready, 1);
        @(posedge CLK);
        #1;
        bus.i_in_valid = 1'b0;
        @(negedge CLK);
        check("t4_zero_pulse", bus.o_zero_drop, 1);
        check("t4_no_wrt", bus.o_pq_wrt, 0);
        check("t4_count_same", bus.o_count, c0);
        repeat (10) tick();
        check("t4_no_write_issued", wrt_times.size(), nw);

        // Reset during SETTLE after a write
        send(5);
        bus.i_in_valid = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        check("t5_rst_wrt", bus.o_pq_wrt, 0);
        check("t5_rst_read", bus.o_pq_read, 0);
        check("t5_rst_pq_data", bus.o_pq_data, 0);
        check("t5_rst_valid", bus.o_out_valid, 0);
        check("t5_rst_out_data", bus.o_out_data, 0);
        check("t5_rst_count", bus.o_count, 0);
        check("t5_rst_zero_drop", bus.o_zero_drop, 0);
        RST = 1'b0;
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = DW'(5);
        #1;
        check("t5_idle_ready", bus.o_in_ready, 1);
        send(5);
        bus.i_in_valid = 1'b0;
        wait_out(v);
        check("t5_readback", v, 5);

        // Nothing to read: no read command, no output
        repeat (10) tick();
        rc = read_cnt;
        repeat (40) tick();
        check("t6_no_read", read_cnt, rc);
        check("t6_no_valid", bus.o_out_valid, 0);
        check("t6_count0", bus.o_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pq_stream_driver.md
Name: pq_stream_driver

Overview:
- Initiator-side driver for the team's register-tree priority queue (PQ). It converts a valid/ready input stream into the PQ's command interface: single-cycle write pulses, read pulses, data bus, and root-data return.
- It sorts items by largest-first and presents them on a valid/ready output stream.
- It enforces the PQ's settle time between commands and keeps its own occupancy count, so it never relies on lagging PQ flags.

Parameters:
- DATA_WIDTH, 16, width of items and of the PQ data bus
- QUEUE_SIZE, 8, PQ capacity; must match the attached PQ
- SETTLE_CYCLES, 6, idle cycles after each command before the next command may issue; legal range 2..255

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- i_in_valid  in  1  upstream item valid
- o_in_ready  out  1  upstream item accepted when high together with i_in_valid
- i_in_data  in  DATA_WIDTH  upstream item
- o_out_valid  out  1  sorted item available
- i_out_ready  in  1  downstream accepts o_out_data
- o_out_data  out  DATA_WIDTH  popped item (PQ maximum)
- i_drain  in  1  read-priority mode: empty the PQ ahead of further writes
- o_pq_wrt  out  1  PQ write command, one-cycle pulse
- o_pq_read  out  1  PQ read command, one-cycle pulse
- o_pq_data  out  DATA_WIDTH  PQ write data
- i_pq_data  in  DATA_WIDTH  PQ root value
- o_count  out  $clog2(QUEUE_SIZE+1)  local PQ occupancy
- o_zero_drop  out  1  one-cycle pulse when a zero item is discarded

Behaviour:
- Reset (RST high at a posedge):
  - state=IDLE; o_pq_wrt=0, o_pq_read=0, o_pq_data=0
  - o_out_valid=0, o_out_data=0, o_count=0, o_zero_drop=0, settle counter=0
  - Reset mid-operation abandons any pending command or settle. The PQ must be reset in the same cycle.
- States: IDLE -> CMD -> SETTLE -> IDLE.
- IDLE: decide the next command. Priority order:
  1. READ if o_count>0, output buffer empty, and (i_drain or o_count==QUEUE_SIZE).
  2. WRITE if i_in_valid and o_count<QUEUE_SIZE and !i_drain.
  3. READ if o_count>0 and output buffer empty.
  4. Otherwise stay in IDLE.
- o_in_ready is combinational: high only in IDLE when WRITE is chosen, or when a zero item is being dropped.
- WRITE decision:
  - o_pq_data is latched from i_in_data.
  - Next state is CMD with o_pq_wrt=1 for exactly 1 cycle.
  - o_count increments at the end of the CMD cycle.
- READ decision:
  - Next state is CMD with o_pq_read=1 for exactly 1 cycle.
  - In the CMD cycle, i_pq_data is captured into o_out_data.
  - o_out_valid=1 from the following cycle.
  - o_count decrements at the end of the CMD cycle.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles, then returns to IDLE.
  - o_pq_wrt and o_pq_read are both 0; o_in_ready=0.
- Command spacing: minimum command-to-command spacing is SETTLE_CYCLES+2 cycles.
- Zero items: the PQ uses 0 as its empty marker, so a zero item is never written.
  - In IDLE, a valid zero item with !i_drain is accepted (o_in_ready=1) and discarded.
  - o_zero_drop pulses; no PQ command is issued and the state stays IDLE.
  - This takes precedence over rule 3, but not over rule 1.
- Output buffer:
  - One entry; it clears on o_out_valid && i_out_ready.
  - A new READ is never decided while the buffer is occupied, so no overwrite can occur.
- Command exclusivity: o_pq_wrt and o_pq_read are never high together, except under the optional replace feature.
- Count saturation: o_count never exceeds QUEUE_SIZE and never underflows.
- i_drain raised mid-CMD or mid-SETTLE takes effect at the next IDLE.

Optional Feature:
- PQ_REPLACE_EN
- Defined: in IDLE, when o_count==QUEUE_SIZE, i_in_valid, nonzero data, output buffer empty, and !i_drain, issue REPLACE.
  - o_pq_wrt=1 and o_pq_read=1 in the same CMD cycle.
  - o_pq_data=i_in_data; the root is captured to o_out_data.
  - o_count is unchanged.
  - REPLACE takes priority over rule 1.
- Undefined: no replace. Full PQ with output buffer empty follows rule 1 (plain READ).

Test Plan:
- Reset, then write 5,9,3 with i_out_ready=0:
  - three o_pq_wrt pulses, each SETTLE_CYCLES+2 apart; o_count=3.
  - No READ is issued yet (rule 3 reads as soon as the buffer is empty, so keep i_in_valid high), then o_out_data=9 valid.
- Fill to QUEUE_SIZE=8 with values 1..8:
  - o_in_ready stays 0 while full; READ fires automatically; o_out_data=8.
  - With PQ_REPLACE_EN and input 20: replace pulse (wrt&read together), o_out_data=8, o_count stays 8.
- i_drain=1 with 4 items (2,7,4,6) and i_out_ready=1:
  - outputs 7,6,4,2 in order; o_in_ready=0 throughout; o_count reaches 0.
- Input item 0:
  - o_in_ready=1, o_zero_drop pulse, no o_pq_wrt, o_count unchanged.
- Assert RST during SETTLE after a write:
  - next cycle all outputs 0, state IDLE; a subsequent write of 5 then read returns 5.
- Read attempted with o_count=0:
  - no o_pq_read ever issued; o_out_valid stays 0.
